// File: rtl/divider_tick_scheduler_if.sv
// divider_tick_scheduler_if: valid/ready channel-configuration port of the tick scheduler.
interface divider_tick_scheduler_if #(
    parameter int LEN_W = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_ch;
    logic             cfg_start;
    logic [4:0]       cfg_tap;
    logic [LEN_W-1:0] cfg_len;
    modport master (output cfg_valid, cfg_ch, cfg_start, cfg_tap, cfg_len, input cfg_ready);
    modport slave (input cfg_valid, cfg_ch, cfg_start, cfg_tap, cfg_len, output cfg_ready);
endinterface

// File: rtl/divider_tick_scheduler.sv
// divider_tick_scheduler: shared free-running prescaler feeding up to four tick-enable channels.
// One-shot tick counting and the done pulse exist only when DIV_SCHED_ONESHOT_EN is defined.
module divider_tick_scheduler #(
    parameter int CNT_W = 18,
    parameter int NCH   = 4,
    parameter int LEN_W = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    divider_tick_scheduler_if.slave cfg,
    output logic [NCH-1:0]          tick,
    output logic [NCH-1:0]          busy,
    output logic [NCH-1:0]          done,
    output logic [CNT_W-1:0]        prescale
);
`ifdef DIV_SCHED_ONESHOT_EN
    typedef enum logic [1:0] {IDLE, RUN, DN} state_t;
`else
    typedef enum logic {IDLE, RUN} state_t;
    logic w_unused_len;
    assign w_unused_len = ^cfg.cfg_len;
    assign done = '0;
`endif
    logic [CNT_W-1:0] r_pre;
    logic             r_ready;
    logic             w_acc;
    logic [4:0]       w_tap;
    assign w_acc         = cfg.cfg_valid && r_ready;
    assign w_tap         = (cfg.cfg_tap > 5'(CNT_W-1)) ? 5'(CNT_W-1) : cfg.cfg_tap;
    assign cfg.cfg_ready = r_ready;
    assign prescale      = r_pre;
    always_ff @(posedge clk) begin
        r_pre   <= rstn ? '0 : r_pre + 1'b1;
        r_ready <= !rstn && !w_acc;
    end
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        state_t     r_state;
        logic [4:0] r_tap;
        logic       w_wr;
        logic       w_tick;
        assign w_wr    = w_acc && cfg.cfg_ch == 2'(c);
        // low tap+1 prescaler bits equal to 1<<tap: one hit per 2^(tap+1) cycles, shared phase
        assign w_tick  = r_state == RUN &&
                         (r_pre & ~(({CNT_W{1'b1}} << r_tap) << 1)) == (CNT_W'(1) << r_tap);
        assign tick[c] = w_tick;
        assign busy[c] = r_state == RUN;
`ifdef DIV_SCHED_ONESHOT_EN
        logic [LEN_W-1:0] r_rem;
        assign done[c] = r_state == DN;
        always_ff @(posedge clk) begin
            if (rstn) begin
                r_state <= IDLE;
                r_tap   <= '0;
                r_rem   <= '0;
            end else if (w_wr) begin
                r_state <= cfg.cfg_start ? RUN : IDLE;
                r_tap   <= cfg.cfg_start ? w_tap : r_tap;
                r_rem   <= cfg.cfg_start ? cfg.cfg_len : r_rem;
            end else if (r_state == DN) begin
                r_state <= IDLE;
            end else if (w_tick && r_rem == LEN_W'(1)) begin
                r_state <= DN;
            end else if (w_tick && r_rem > LEN_W'(1)) begin
                r_rem <= r_rem - 1'b1;
            end
        end
`else
        always_ff @(posedge clk) begin
            if (rstn) begin
                r_state <= IDLE;
                r_tap   <= '0;
            end else if (w_wr) begin
                r_state <= cfg.cfg_start ? RUN : IDLE;
                r_tap   <= cfg.cfg_start ? w_tap : r_tap;
            end
        end
`endif
    end
endmodule

// File: doc/divider_tick_scheduler.md
# divider_tick_scheduler

Synchronous clock-enable scheduler for the frequency-division datapath. It contains one free-running 18-bit prescale counter and shares it among up to four channels. Each channel is programmed through a valid/ready config port with a tap bit and, optionally, a tick count. It emits single-cycle `tick` enables at `clk / 2^(tap+1)`, so downstream logic runs on `clk` with enables instead of rippled derived clocks.

## Interface
- `CNT_W`, 18, prescale counter width; valid tap range is 0..CNT_W-1
- `NCH`, 4, number of channels (1..4)
- `LEN_W`, 8, one-shot tick-count width
- `clk`  in  1  sole clock; all state updates on rising edge
- `rstn`  in  1  synchronous, active-high reset; `rstn`=1 at a rising edge clears all state
- `cfg_valid`  in  1  config write request
- `cfg_ready`  out  1  scheduler can accept a write
- `cfg_ch`  in  2  target channel; values >= NCH are accepted and discarded
- `cfg_start`  in  1  1 = start/restart channel, 0 = stop channel
- `cfg_tap`  in  5  tap select; values > CNT_W-1 clamp to CNT_W-1
- `cfg_len`  in  LEN_W  tick count; 0 = continuous
- `tick`  out  NCH  per-channel one-cycle enable pulse
- `busy`  out  NCH  channel is in RUN
- `done`  out  NCH  one-cycle pulse when a one-shot completes
- `prescale`  out  CNT_W  current prescale counter value

## Operation
- Prescale counter:
  - `prescale` increments by 1 every cycle.
  - It wraps from 2^CNT_W-1 to 0.
  - It is never cleared by config writes, only by reset.
- Accepted write: `cfg_valid && cfg_ready` at a rising edge.
- `cfg_ready`:
  - 0 on the first cycle after an accepted write.
  - 1 otherwise, outside reset.
  - Back-to-back writes therefore take 2 cycles each.
- Per-channel state machine with states IDLE, RUN, DONE:
  - IDLE -> RUN on an accepted start write. The write latches the clamped `cfg_tap`, and latches `cfg_len` into `remaining`.
  - RUN -> RUN on a start write (restart): tap and `remaining` are reloaded.
  - RUN -> IDLE on a stop write. A stop write to an IDLE or DONE channel forces IDLE.
  - RUN -> DONE on a tick while `remaining`==1. No other tick decrements `remaining` below 1.
  - DONE -> IDLE unconditionally after one cycle. A start write landing in DONE is honored and goes to RUN, with no pass through IDLE.
- Tick generation:
  - `tick[c]` = (state==RUN) && (`prescale[tap:0]` == 1<<tap). It is combinational from registered state.
  - Tick period is exactly 2^(tap+1) cycles.
  - Ticks are phase-locked to the shared prescaler, so channels with equal taps tick in the same cycle.
- Output flags:
  - `done[c]` = (state==DONE).
  - `busy[c]` = (state==RUN).
- Simultaneous events:
  - A write to channel c in the same cycle as its tick: the tick is emitted in that cycle, and the write's effect replaces any decrement or DONE transition.
  - A stop write that coincides with the final tick yields no `done` pulse.
- Writes to different channels never interact. Only one write is accepted per 2 cycles.

## Timing
- Reset values:
  - `prescale`=0, `tick`=0, `busy`=0, `done`=0, all channels IDLE.
  - `cfg_ready`=0 while `rstn`=1 is sampled, and 1 on the first cycle after.
- Reset during RUN: the channel is in IDLE on the next cycle, emits no `done`, and `prescale` restarts at 0.
- Write latency: a write accepted at edge k shows `busy` at edge k (visible in cycle k+1).
- First tick after start lies between 1 and 2^(tap+1) cycles after acceptance, depending on prescaler phase.
- One-shot of length L: exactly L ticks, then `done` for 1 cycle in the cycle after the last tick, then IDLE.
- `tick` and `done` are never both high on the same channel.

## Configuration
- Macro `DIV_SCHED_ONESHOT_EN`.
- Defined: one-shot mode as described; `cfg_len`>0 counts ticks, and `done` is functional.
- Undefined: `cfg_len` is ignored and every start is continuous. The DONE state and `remaining` counters are not built. `done` is tied to 0. RUN exits only via stop write or reset.

## Test plan
- Reset release → `prescale` reads 0,1,2… on successive cycles; `cfg_ready`=1 one cycle after release; all `tick`, `busy`, `done`=0.
- Start ch0, tap=0, len=0 → `tick[0]` asserts every 2 cycles, whenever `prescale[0]`==1; stop write → `busy[0]`=0 next cycle, no further ticks.
- Start ch1, tap=3, len=3 (ONESHOT_EN) → ticks when `prescale[3:0]`==8, 16 cycles apart; exactly 3 ticks; `done[1]`=1 for 1 cycle right after the third; then `busy[1]`=0.
- Two writes on consecutive cycles → second is held because `cfg_ready`=0; it is accepted one cycle later; tap=25 is clamped to 17 (period 2^18).
- Stop write to ch2 coinciding with its final one-shot tick → tick is seen, `done[2]` stays 0, ch2 returns to IDLE.
- Assert `rstn` mid-run with ch0–ch3 busy → next cycle all outputs are 0 and `prescale`=0; the first write after release is accepted normally.
